// File: rtl/dm_responder.sv
// Word-organised data memory that answers CPU load/store requests after a fixed number of wait states.
// Optional out-of-range error reporting is enabled by defining DM_ERR_EN.
module dm_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned IDX_W = DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic             cap_write;
    logic [IDX_W-1:0] cap_idx;
    logic [31:0]      cap_wdata;
    logic [3:0]       cap_be;

    logic             accept;
    logic             do_access;
    logic             rsp_done;
    logic             acc_write;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]      acc_wdata;
    logic [3:0]       acc_be;
    logic [31:0]      rd_data;

    logic [31:0]      req_off;
    logic [IDX_W-1:0] req_idx;

    logic [31:0]      mem [DEPTH];

`ifdef DM_ERR_EN
    logic             req_oor;
    logic             cap_oor;
    logic             acc_oor;
`endif

    // Word index relative to the base; unsigned wrap makes addresses below the base land far out of range.
    always_comb begin
        req_off = req_addr - ADDR_BASE;
        req_idx = IDX_W'(req_off >> 2);
`ifdef DM_ERR_EN
        req_oor = (req_off >> (DEPTH_LOG2 + 2)) != 32'd0;
`endif
    end

    assign req_ready = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // With zero wait states the access uses the live request; otherwise the captured one.
    always_comb begin
        accept    = 1'b0;
        do_access = 1'b0;
        rsp_done  = 1'b0;
        acc_write = cap_write;
        acc_idx   = cap_idx;
        acc_wdata = cap_wdata;
        acc_be    = cap_be;
`ifdef DM_ERR_EN
        acc_oor   = cap_oor;
`endif
        case (state)
            S_IDLE: begin
                accept = req_valid;
                if (WAIT_CYCLES == 0) begin
                    do_access = req_valid;
                    acc_write = req_write;
                    acc_idx   = req_idx;
                    acc_wdata = req_wdata;
                    acc_be    = req_be;
`ifdef DM_ERR_EN
                    acc_oor   = req_oor;
`endif
                end
            end
            S_WAIT:  do_access = (cnt == CNT_W'(1));
            S_RESP:  rsp_done  = rsp_ready;
            default: ;
        endcase
    end

    always_comb begin
        rd_data = acc_write ? 32'd0 : mem[acc_idx];
`ifdef DM_ERR_EN
        if (acc_oor) rd_data = 32'd0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_write <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef DM_ERR_EN
            cap_oor   <= 1'b0;
            rsp_err   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                cap_write <= req_write;
                cap_idx   <= req_idx;
                cap_wdata <= req_wdata;
                cap_be    <= req_be;
`ifdef DM_ERR_EN
                cap_oor   <= req_oor;
`endif
            end
            if (do_access) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= rd_data;
`ifdef DM_ERR_EN
                rsp_err   <= acc_oor;
`endif
            end else if (rsp_done) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifndef DM_ERR_EN
    assign rsp_err = 1'b0;
`endif

    // Storage is never reset; a store commits only on its access edge and only when reset is low.
    always_ff @(posedge clk) begin
        if (!rst && do_access && acc_write
`ifdef DM_ERR_EN
            && !acc_oor
`endif
           ) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder (WAIT_CYCLES=2, DEPTH_LOG2=10).
module tb_dm_responder;

    localparam int unsigned WAIT = 2;
    localparam int          LAT  = 3;   // accept edge to first rsp_valid cycle
    localparam int          GAP  = 4;   // accept-to-accept spacing back to back
    localparam int          TMO  = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dm_responder #(
        .ADDR_BASE  (32'h0000_0000),
        .DEPTH_LOG2 (10),
        .WAIT_CYCLES(WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, check its latency and return the response fields.
    task automatic transact(input string name, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            output logic [31:0] rdata, output logic err);
        int n;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        n = 0;
        while (!req_ready && n < TMO) begin
            tick();
            n++;
        end
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < TMO) begin
            tick();
            n++;
        end
        tests++;
        if (rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s timeout: rsp_valid=%b after %0d cycles, required 1", name, rsp_valid, n);
        end else if (n != LAT) begin
            fails++;
            $display("FAIL %s latency: got %0d cycles, required %0d", name, n, LAT);
        end
        rdata     = rsp_rdata;
        err       = rsp_err;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_req_ready: got %b, required 1", req_ready);
        end
        tests++;
        if (rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid);
        end
        tests++;
        if (rsp_rdata !== 32'd0) begin
            fails++;
            $display("FAIL reset_rsp_rdata: got %h, required 00000000", rsp_rdata);
        end
        tests++;
        if (rsp_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_rsp_err: got %b, required 0", rsp_err);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic        er;
        transact("store_full", 1'b1, 32'h10, 32'h1234_5678, 4'hF, rd, er);
        tests++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            fails++;
            $display("FAIL store_full_rsp: got rdata=%h err=%b, required 00000000/0", rd, er);
        end
        transact("load_full", 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        tests++;
        if (rd !== 32'h1234_5678 || er !== 1'b0) begin
            fails++;
            $display("FAIL load_full: got rdata=%h err=%b, required 12345678/0", rd, er);
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd;
        logic        er;
        transact("store_be5", 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, rd, er);
        tests++;
        if (rd !== 32'd0) begin
            fails++;
            $display("FAIL store_be5_rdata: got %h, required 00000000", rd);
        end
        transact("load_be5", 1'b0, 32'h10, 32'h0, 4'hF, rd, er);
        tests++;
        if (rd !== 32'h12BB_56DD) begin
            fails++;
            $display("FAIL load_be5: got %h, required 12bb56dd", rd);
        end
        transact("load_unaligned", 1'b0, 32'h13, 32'h0, 4'h0, rd, er);
        tests++;
        if (rd !== 32'h12BB_56DD) begin
            fails++;
            $display("FAIL load_unaligned: got %h, required 12bb56dd", rd);
        end
        transact("store_be0", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, rd, er);
        transact("load_after_be0", 1'b0, 32'h10, 32'h0, 4'hF, rd, er);
        tests++;
        if (rd !== 32'h12BB_56DD) begin
            fails++;
            $display("FAIL load_after_be0: got %h, required 12bb56dd", rd);
        end
    endtask

    task automatic test_stall();
        logic [31:0] rd;
        logic        er;
        int          n;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < TMO) begin
            tick();
            n++;
        end
        // Competing store held during the stall must not be taken.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'hFFFF_FFFF;
        req_be    = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12BB_56DD || req_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_cycle%0d: got valid=%b rdata=%h ready=%b, required 1/12bb56dd/0",
                         i, rsp_valid, rsp_rdata, req_ready);
            end
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_release: got valid=%b ready=%b, required 0/1", rsp_valid, req_ready);
        end
        transact("load_after_stall", 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        tests++;
        if (rd !== 32'h12BB_56DD) begin
            fails++;
            $display("FAIL load_after_stall: got %h, required 12bb56dd", rd);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd;
        logic        er;
        int          n;
        transact("store_prior", 1'b1, 32'h20, 32'h5555_AAAA, 4'hF, rd, er);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hDEAD_BEEF;
        req_be    = 4'hF;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_wait_state: got valid=%b ready=%b, required 0/1", rsp_valid, req_ready);
        end
        transact("load_dropped", 1'b0, 32'h20, 32'h0, 4'h0, rd, er);
        tests++;
        if (rd !== 32'h5555_AAAA) begin
            fails++;
            $display("FAIL reset_in_wait_data: got %h, required 5555aaaa", rd);
        end
        // Reset in RESP: the store has already committed.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h24;
        req_wdata = 32'hCAFE_F00D;
        req_be    = 4'hF;
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < TMO) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_in_resp_valid: got %b, required 0", rsp_valid);
        end
        transact("load_committed", 1'b0, 32'h24, 32'h0, 4'h0, rd, er);
        tests++;
        if (rd !== 32'hCAFE_F00D) begin
            fails++;
            $display("FAIL reset_in_resp_data: got %h, required cafef00d", rd);
        end
    endtask

    task automatic test_range();
        logic [31:0] rd;
        logic        er;
        transact("store_word0", 1'b1, 32'h0, 32'h1111_1111, 4'hF, rd, er);
        transact("store_oor", 1'b1, 32'h1000, 32'h0BAD_F00D, 4'hF, rd, er);
`ifdef DM_ERR_EN
        tests++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            fails++;
            $display("FAIL range_store_err: got err=%b rdata=%h, required 1/00000000", er, rd);
        end
        transact("load_word0", 1'b0, 32'h0, 32'h0, 4'h0, rd, er);
        tests++;
        if (rd !== 32'h1111_1111 || er !== 1'b0) begin
            fails++;
            $display("FAIL range_store_suppressed: got rdata=%h err=%b, required 11111111/0", rd, er);
        end
        transact("load_oor", 1'b0, 32'h1000, 32'h0, 4'h0, rd, er);
        tests++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            fails++;
            $display("FAIL range_load_err: got err=%b rdata=%h, required 1/00000000", er, rd);
        end
`else
        tests++;
        if (er !== 1'b0) begin
            fails++;
            $display("FAIL range_store_noerr: got err=%b, required 0", er);
        end
        transact("load_word0", 1'b0, 32'h0, 32'h0, 4'h0, rd, er);
        tests++;
        if (rd !== 32'h0BAD_F00D || er !== 1'b0) begin
            fails++;
            $display("FAIL range_alias_word0: got rdata=%h err=%b, required 0badf00d/0", rd, er);
        end
        transact("load_oor", 1'b0, 32'h1000, 32'h0, 4'h0, rd, er);
        tests++;
        if (rd !== 32'h0BAD_F00D) begin
            fails++;
            $display("FAIL range_alias_1000: got %h, required 0badf00d", rd);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$];
        int n;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        rsp_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (req_ready) acc_cyc.push_back(c);
            tick();
        end
        req_valid = 1'b0;
        n = 0;
        while (!req_ready && n < TMO) begin
            tick();
            n++;
        end
        rsp_ready = 1'b0;
        tests++;
        if (acc_cyc.size() != 3) begin
            fails++;
            $display("FAIL b2b_accept_count: got %0d, required 3", acc_cyc.size());
        end else begin
            tests++;
            if (acc_cyc[1] - acc_cyc[0] != GAP || acc_cyc[2] - acc_cyc[1] != GAP) begin
                fails++;
                $display("FAIL b2b_spacing: got %0d,%0d cycles, required %0d",
                         acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1], GAP);
            end
        end
        tests++;
        if (req_ready !== 1'b1 || rsp_rdata !== 32'h12BB_56DD) begin
            fails++;
            $display("FAIL b2b_drain: got ready=%b rdata=%h, required 1/12bb56dd", req_ready, rsp_rdata);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_be    = 4'h0;
        rsp_ready = 1'b0;
        test_reset();
        test_store_load();
        test_byte_enable();
        test_stall();
        test_reset_mid_op();
        test_back_to_back();
        test_range();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
